// File: rtl/cbus_ram_responder_if.sv
// cbus_ram_responder_if: request/response signals of one cbus link
interface cbus_ram_responder_if;
  logic        creq_valid;
  logic        creq_is_write;
  logic [31:0] creq_addr;
  logic [3:0]  creq_len;
  logic [3:0]  creq_strobe;
  logic [31:0] creq_data;
  logic        cresp_ready;
  logic        cresp_last;
  logic [31:0] cresp_data;
  modport master (
    output creq_valid, creq_is_write, creq_addr, creq_len, creq_strobe, creq_data,
    input  cresp_ready, cresp_last, cresp_data
  );
  modport slave (
    input  creq_valid, creq_is_write, creq_addr, creq_len, creq_strobe, creq_data,
    output cresp_ready, cresp_last, cresp_data
  );
endinterface

// File: rtl/cbus_ram_responder.sv
// cbus_ram_responder: RAM-backed cbus target with wrapping bursts and programmable first-beat latency
module cbus_ram_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic                  clk,
  input logic                  resetn,
  cbus_ram_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  state_t          state_q, state_d;
  logic            wr_q, wr_d;
  logic [3:0]      len_q, len_d, off_q, off_d, beat_q, beat_d;
  logic [AW-1:0]   base_q, base_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [31:0]     mem [DEPTH_WORDS];
  logic [3:0]      len_n;
  logic [AW-1:0]   ram_idx;
  logic            beat;
  // illegal lengths round up to the next all-ones mask
  assign len_n   = bus.creq_len | bus.creq_len >> 1 | bus.creq_len >> 2 | bus.creq_len >> 3;
  assign ram_idx = base_q | AW'(off_q);
  assign beat    = state_q == BURST;
  assign bus.cresp_ready = beat;
  assign bus.cresp_last  = beat && beat_q == len_q;
  assign bus.cresp_data  = beat && !wr_q ? mem[ram_idx] : '0;
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    len_d   = len_q;
    off_d   = off_q;
    beat_d  = beat_q;
    base_d  = base_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: if (bus.creq_valid) begin
        wr_d    = bus.creq_is_write;
        len_d   = len_n;
        base_d  = bus.creq_addr[AW+1:2] & ~AW'(len_n);
        off_d   = bus.creq_addr[5:2] & len_n;
        beat_d  = '0;
        lat_d   = LW'(LATENCY);
        state_d = LATENCY == 0 ? BURST : WAIT;
      end
      WAIT: begin
        lat_d   = lat_q - 1'b1;
        state_d = lat_q == LW'(1) ? BURST : WAIT;
      end
      BURST: begin
        beat_d  = beat_q + 4'd1;
        off_d   = (off_q + 4'd1) & len_q;
        state_d = beat_q == len_q ? DONE : BURST;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      len_q   <= '0;
      off_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      off_q   <= off_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      lat_q   <= lat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (resetn && beat && wr_q)
      for (int i = 0; i < 4; i++)
        if (bus.creq_strobe[i]) mem[ram_idx][8*i +: 8] <= bus.creq_data[8*i +: 8];
  end
endmodule

// File: tb/tb_cbus_ram_responder.sv
// tb_cbus_ram_responder: directed vector table plus reset-mid-burst sequence
module tb_cbus_ram_responder;
  typedef struct {
    bit          dut;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  strb;
    logic [31:0] wd;
    int          n;
    logic [31:0] exp [16];
  } vec_t;
  logic clk = 1'b0, resetn = 1'b0;
  logic sel = 1'b0, valid = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, data = '0;
  logic [3:0] len = '0, strb = '0;
  logic rdy, last;
  logic [31:0] rdata;
  int checks = 0, errors = 0, nv = 0;
  vec_t tbl [16];
  cbus_ram_responder_if b0();
  cbus_ram_responder_if b1();
  assign b0.creq_valid = valid & ~sel;
  assign b1.creq_valid = valid & sel;
  assign b0.creq_is_write = wr;
  assign b1.creq_is_write = wr;
  assign b0.creq_addr = addr;
  assign b1.creq_addr = addr;
  assign b0.creq_len = len;
  assign b1.creq_len = len;
  assign b0.creq_strobe = strb;
  assign b1.creq_strobe = strb;
  assign b0.creq_data = data;
  assign b1.creq_data = data;
  assign rdy   = sel ? b1.cresp_ready : b0.cresp_ready;
  assign last  = sel ? b1.cresp_last : b0.cresp_last;
  assign rdata = sel ? b1.cresp_data : b0.cresp_data;
  cbus_ram_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (.clk(clk), .resetn(resetn), .bus(b0));
  cbus_ram_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_lat0 (.clk(clk), .resetn(resetn), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input bit d, input bit w, input logic [31:0] a, input logic [3:0] l,
                     input logic [3:0] s, input logic [31:0] wd, input int n);
    tbl[nv].dut  = d;
    tbl[nv].wr   = w;
    tbl[nv].addr = a;
    tbl[nv].len  = l;
    tbl[nv].strb = s;
    tbl[nv].wd   = wd;
    tbl[nv].n    = n;
    for (int k = 0; k < 16; k++) tbl[nv].exp[k] = '0;
    nv++;
  endtask
  task automatic run(input int id, input vec_t v);
    int lat;
    lat = v.dut ? 0 : 2;
    @(negedge clk);
    sel = v.dut; valid = 1'b1; wr = v.wr; addr = v.addr; len = v.len; strb = v.strb; data = v.wd;
    @(posedge clk);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d wait%0d ready", id, c), {31'b0, rdy}, 32'd0);
    end
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      data = v.wd + k;
      chk($sformatf("v%0d beat%0d ready", id, k), {31'b0, rdy}, 32'd1);
      chk($sformatf("v%0d beat%0d last", id, k), {31'b0, last}, {31'b0, k == v.n - 1});
      if (!v.wr) chk($sformatf("v%0d beat%0d rdata", id, k), rdata, v.exp[k]);
    end
    @(negedge clk);
    chk($sformatf("v%0d done ready", id), {31'b0, rdy}, 32'd0);
    valid = 1'b0;
  endtask
  initial begin
    int rot [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    add(0, 1, 32'h40, 0, 4'hF, 32'hDEADBEEF, 1);
    add(0, 0, 32'h40, 0, 4'h0, 32'h0, 1);   tbl[1].exp[0] = 32'hDEADBEEF;
    add(0, 1, 32'h80, 3, 4'hF, 32'h100, 4);
    add(0, 0, 32'h88, 3, 4'h0, 32'h0, 4);
    tbl[3].exp[0] = 32'h102; tbl[3].exp[1] = 32'h103; tbl[3].exp[2] = 32'h100; tbl[3].exp[3] = 32'h101;
    add(0, 0, 32'h88, 2, 4'h0, 32'h0, 4);
    tbl[4].exp[0] = 32'h102; tbl[4].exp[1] = 32'h103; tbl[4].exp[2] = 32'h100; tbl[4].exp[3] = 32'h101;
    add(0, 1, 32'h14, 0, 4'hF, 32'h11223344, 1);
    add(0, 1, 32'h14, 0, 4'b0101, 32'hAABBCCDD, 1);
    add(0, 1, 32'h14, 0, 4'h0, 32'hFFFFFFFF, 1);
    add(0, 0, 32'h14, 0, 4'h0, 32'h0, 1);   tbl[8].exp[0] = 32'h11BB33DD;
    add(0, 1, 32'h100, 15, 4'hF, 32'h0, 16);
    add(0, 0, 32'h100, 15, 4'h0, 32'h0, 16);
    for (int k = 0; k < 16; k++) tbl[10].exp[k] = k;
    add(0, 0, 32'h114, 7, 4'h0, 32'h0, 8);
    for (int k = 0; k < 8; k++) tbl[11].exp[k] = rot[k];
    add(0, 0, 32'h1040, 0, 4'h0, 32'h0, 1); tbl[12].exp[0] = 32'hDEADBEEF;
    add(1, 1, 32'h1000, 0, 4'hF, 32'hCAFEF00D, 1);
    add(1, 0, 32'h0, 0, 4'h0, 32'h0, 1);    tbl[14].exp[0] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready0", {31'b0, b0.cresp_ready}, 32'd0);
    chk("reset last0", {31'b0, b0.cresp_last}, 32'd0);
    chk("reset data0", b0.cresp_data, 32'd0);
    chk("reset ready1", {31'b0, b1.cresp_ready}, 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < nv; i++) run(i, tbl[i]);
    @(negedge clk);
    sel = 1'b0; valid = 1'b1; wr = 1'b0; addr = 32'h100; len = 4'd7;
    @(posedge clk);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst burst beat%0d", k), rdata, k);
    end
    @(negedge clk);
    chk("rst burst beat3", rdata, 32'd3);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst abort ready", {31'b0, rdy}, 32'd0);
    chk("rst abort last", {31'b0, last}, 32'd0);
    chk("rst abort data", rdata, 32'd0);
    valid = 1'b0;
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst idle%0d ready", c), {31'b0, rdy}, 32'd0);
    end
    run(100, tbl[10]);
    run(101, tbl[8]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
